// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - Data-cache request/ready port between the MEM stage and the D-cache.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_wen;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_wen,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_wen,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: D-cache load/store with stall and timeout watchdog.
// Optional macro MISALIGN_CHK_EN: misaligned accesses complete immediately with mem_err instead of issuing.
module mem_access_stage #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic                       reg_write,
    input  logic                       mem_to_reg,
    input  logic                       is_jal,
    input  logic [4:0]                 write_reg,
    input  logic [31:0]                alu_result,
    input  logic [31:0]                store_data,
    input  logic [31:0]                pc_plus_4,
    mem_access_stage_if.master         dmem,
    output logic                       mem_stall,
    output logic                       regwrite_o,
    output logic                       memtoreg_o,
    output logic [4:0]                 write_reg_o,
    output logic [31:0]                read_data_o,
    output logic [31:0]                address_o,
    output logic                       mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic               wen_q, wen_d;
    logic [29:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   wd_q, wd_d;
    logic               err_q, err_d;
    logic               op;
    logic               issue;
    logic               wr_block;

    assign op = mem_read | mem_write;

`ifdef MISALIGN_CHK_EN
    logic mis_q, mis_d;
    logic misaligned;

    assign misaligned = alu_result[1:0] != 2'b00;
    // Suppress write-back both while the bad access is being rejected and in its DONE cycle.
    assign wr_block   = mis_q | ((state_q == IDLE) & op & misaligned);
`else
    assign wr_block   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wd_d      = wd_q;
        err_d     = err_q;
        issue     = 1'b0;
        mem_stall = 1'b0;
`ifdef MISALIGN_CHK_EN
        mis_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                mem_stall = op;
                if (op) begin
`ifdef MISALIGN_CHK_EN
                    if (misaligned) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        issue = 1'b1;
                    end
`else
                    issue = 1'b1;
`endif
                end
                if (issue) begin
                    req_d   = 1'b1;
                    wen_d   = mem_write & ~mem_read;
                    addr_d  = alu_result[31:2];
                    wdata_d = store_data;
                    wd_d    = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                // A ready on the final watchdog cycle still wins over the timeout.
                if (dmem.dmem_ready) begin
                    rdata_d = dmem.dmem_rdata;
                    req_d   = 1'b0;
                    wd_d    = '0;
                    state_d = DONE;
                end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    wd_d    = '0;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

`ifdef MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
`endif

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_wen   = wen_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign regwrite_o  = (reg_write | is_jal) & ~wr_block;
    assign memtoreg_o  = mem_to_reg & ~is_jal;
    assign write_reg_o = is_jal ? 5'd31 : write_reg;
    assign address_o   = is_jal ? pc_plus_4 : alu_result;
    assign read_data_o = rdata_q;
    assign mem_err     = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - Directed scoreboard bench for mem_access_stage.
module tb_mem_access_stage;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read, mem_write, reg_write, mem_to_reg, is_jal;
    logic [4:0]  write_reg;
    logic [31:0] alu_result, store_data, pc_plus_4;
    logic        mem_stall, regwrite_o, memtoreg_o, mem_err;
    logic [4:0]  write_reg_o;
    logic [31:0] read_data_o, address_o;

    mem_access_stage_if dmem ();

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .is_jal      (is_jal),
        .write_reg   (write_reg),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .pc_plus_4   (pc_plus_4),
        .dmem        (dmem),
        .mem_stall   (mem_stall),
        .regwrite_o  (regwrite_o),
        .memtoreg_o  (memtoreg_o),
        .write_reg_o (write_reg_o),
        .read_data_o (read_data_o),
        .address_o   (address_o),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic err_exp  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one memory op; the cache model answers k cycles after dmem_req rises.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd_val, input int k);
        exp_t e;
        int   stalls;
        int   reqc;
        bit   ok;
        e.addr   = addr[31:2];
        e.wen    = wr & ~rd;
        e.wdata  = wd;
        e.rdata  = (k >= TIMEOUT) ? 32'd0 : rd_val;
        if (k >= TIMEOUT) err_exp = 1'b1;
        e.err    = err_exp;
        e.stalls = (k >= TIMEOUT) ? TIMEOUT + 1 : k + 2;
        sb.push_back(e);

        mem_read   = rd;
        mem_write  = wr;
        alu_result = addr;
        store_data = wd;
        mem_to_reg = rd;
        reg_write  = rd;
        is_jal     = 1'b0;
        write_reg  = 5'd8;
        #1;
        stalls = 0;
        reqc   = 0;
        ok     = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!mem_stall) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            if (dmem.dmem_req) begin
                reqc++;
                chk("dmem_addr", {2'b00, dmem.dmem_addr}, {2'b00, sb[0].addr});
                chk("dmem_wen", dmem.dmem_wen, sb[0].wen);
                chk("dmem_wdata", dmem.dmem_wdata, sb[0].wdata);
                if (reqc == k + 1) begin
                    dmem.dmem_ready = 1'b1;
                    dmem.dmem_rdata = rd_val;
                end
            end
            tick();
            dmem.dmem_ready = 1'b0;
            dmem.dmem_rdata = 32'h0BAD_F00D;
            #1;
        end
        chk("done_within_budget", ok, 1'b1);
        e = sb.pop_front();
        chk("stall_cycles", stalls, e.stalls);
        chk("done_req_low", dmem.dmem_req, 1'b0);
        chk("mem_err", mem_err, e.err);
        if (!e.wen) chk("read_data_o", read_data_o, e.rdata);
        tick();
    endtask

    initial begin
        mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0; is_jal = 0;
        write_reg = 0; alu_result = 0; store_data = 0; pc_plus_4 = 0;
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_req", dmem.dmem_req, 1'b0);
        chk("rst_wen", dmem.dmem_wen, 1'b0);
        chk("rst_addr", {2'b00, dmem.dmem_addr}, 32'd0);
        chk("rst_wdata", dmem.dmem_wdata, 32'd0);
        chk("rst_rdata", read_data_o, 32'd0);
        chk("rst_err", mem_err, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        rst = 1'b0;
        tick();

        // ALU instruction passes straight through
        reg_write = 1; write_reg = 5'd5; alu_result = 32'h0000_0010; mem_to_reg = 0;
        #1;
        chk("add_address", address_o, 32'h10);
        chk("add_regwrite", regwrite_o, 1'b1);
        chk("add_write_reg", write_reg_o, 5'd5);
        chk("add_memtoreg", memtoreg_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("add_stall", mem_stall, 1'b0);
            chk("add_req", dmem.dmem_req, 1'b0);
            tick();
        end

        // JAL link muxing
        is_jal = 1; pc_plus_4 = 32'h0000_0044; reg_write = 0; mem_to_reg = 1;
        write_reg = 5'd3; alu_result = 32'h99;
        #1;
        chk("jal_regwrite", regwrite_o, 1'b1);
        chk("jal_write_reg", write_reg_o, 5'd31);
        chk("jal_address", address_o, 32'h44);
        chk("jal_memtoreg", memtoreg_o, 1'b0);
        chk("jal_stall", mem_stall, 1'b0);
        tick();
        is_jal = 0;

        access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3);
        // Store with ready on the request cycle, then a load issued back-to-back
        access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 0);
        access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_0001, 1);
        // Both read and write set: behaves as a read
        access(1'b1, 1'b1, 32'h0000_0400, 32'h5555_AAAA, 32'h7777_0000, 2);
`ifndef MISALIGN_CHK_EN
        access(1'b1, 1'b0, 32'h0000_0107, 32'h0, 32'h0102_0304, 0);
`endif
        // Ready on the last watchdog cycle still completes cleanly
        access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h600D_600D, TIMEOUT - 1);
        access(1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'hFFFF_FFFF, 1000);
        // mem_err is sticky across a later good access
        access(1'b1, 1'b0, 32'h0000_0700, 32'h0, 32'h1111_2222, 0);
        mem_read = 0; mem_write = 0;
        tick();

        // Reset in the middle of an outstanding access
        mem_read = 1; alu_result = 32'h0000_0200;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (dmem.dmem_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("mid_req_seen", seen, 1'b1);
        end
        rst = 1'b1;
        mem_read = 0;
        err_exp = 1'b0;
        #1;
        chk("midrst_req", dmem.dmem_req, 1'b0);
        chk("midrst_stall", mem_stall, 1'b0);
        chk("midrst_err", mem_err, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_stall", mem_stall, 1'b0);
            chk("post_rst_req", dmem.dmem_req, 1'b0);
        end
        access(1'b1, 1'b0, 32'h0000_0800, 32'h0, 32'hABCD_0123, 2);
        mem_read = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
